// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone shared-bus arbiter.
// Grants the bus to one master for the whole CYC assertion and rotates
// priority on every release. An optional stall watchdog raises a one-cycle
// timeout_err when the granted transfer is never acknowledged.
module wb_arbiter_rr #(
    parameter int NUMM    = 2,
    parameter int TIMEOUT = 256,
    localparam int IDXW   = (NUMM > 1) ? $clog2(NUMM) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NUMM-1:0] m_cyc,
    input  logic            bus_stb,
    input  logic            bus_ack,
    input  logic            bus_err,
    output logic [NUMM-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            busy,
    output logic            timeout_err
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NUMM-1:0]   r_gnt;
    logic [NUMM-1:0]   w_gnt_nxt;
    logic [IDXW-1:0]   r_gnt_idx;
    logic [IDXW-1:0]   w_idx_nxt;
    logic [IDXW-1:0]   r_last;
    logic [IDXW-1:0]   w_last_nxt;
    logic [IDXW-1:0]   w_base;
    logic [IDXW-1:0]   w_pick_idx;
    logic              w_pick_valid;
    logic              w_owner_req;

    assign gnt         = r_gnt;
    assign gnt_idx     = r_gnt_idx;
    assign busy        = (r_state == ST_GRANT);
    assign w_owner_req = m_cyc[r_gnt_idx];

    // While granted the scan starts after the current owner, which is exactly
    // the value 'last' takes on release, so the handover pick is ready the
    // same cycle and a released owner is automatically lowest priority.
    assign w_base = (r_state == ST_GRANT) ? r_gnt_idx : r_last;

    // Round-robin pick: the requester at the smallest circular distance past w_base.
    always_comb begin
        int unsigned v_base;
        int unsigned v_dist;
        int unsigned v_best;
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        v_base       = 32'(w_base);
        v_dist       = 0;
        v_best       = unsigned'(NUMM);
        for (int unsigned i = 0; i < unsigned'(NUMM); i++) begin
            if (m_cyc[i]) begin
                v_dist = (i + unsigned'(NUMM) - v_base - 1) % unsigned'(NUMM);
                if (v_dist < v_best) begin
                    v_best       = v_dist;
                    w_pick_valid = 1'b1;
                    w_pick_idx   = IDXW'(i);
                end
            end
        end
    end

    // Grant FSM next-state: acquire from idle, hold while owner keeps CYC, hand over on release.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_gnt_idx;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt             = ST_GRANT;
                    w_gnt_nxt               = '0;
                    w_gnt_nxt[w_pick_idx]   = 1'b1;
                    w_idx_nxt               = w_pick_idx;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req) begin
                    w_last_nxt = r_gnt_idx;
                    if (w_pick_valid) begin
                        w_gnt_nxt             = '0;
                        w_gnt_nxt[w_pick_idx] = 1'b1;
                        w_idx_nxt             = w_pick_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // Grant FSM state register; reset makes master 0 the first winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_last    <= IDXW'(NUMM - 1);
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_idx_nxt;
            r_last    <= w_last_nxt;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int              CW    = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT - 1);

            logic [CW-1:0] r_wd_cnt;
            logic          r_terr;
            logic          w_stall;

            // Owner still holding CYC means the grant does not change on this edge.
            assign w_stall = (r_state == ST_GRANT) && w_owner_req &&
                             bus_stb && !bus_ack && !bus_err;

            // Stall watchdog: count unacknowledged strobe cycles, pulse at the limit.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_wd_cnt <= '0;
                    r_terr   <= 1'b0;
                end else if (w_stall) begin
                    if (r_wd_cnt == LIMIT) begin
                        r_wd_cnt <= '0;
                        r_terr   <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                        r_terr   <= 1'b0;
                    end
                end else begin
                    r_wd_cnt <= '0;
                    r_terr   <= 1'b0;
                end
            end

            assign timeout_err = r_terr;
        end else begin : g_no_wdog
            logic w_unused_bus;
            assign w_unused_bus = ^{bus_stb, bus_ack, bus_err};
            assign timeout_err  = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Self-checking bench for wb_arbiter_rr: a 2-master instance with an 8-cycle
// watchdog and a 4-master instance with the watchdog disabled, driven from a
// directed vector list with a scoreboard queue checked by a separate monitor.
module tb_wb_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] m_cyc2 = '0;
    logic [3:0] m_cyc4 = '0;
    logic       bus_stb = 1'b0;
    logic       bus_ack = 1'b0;
    logic       bus_err = 1'b0;

    logic [1:0] gnt2;
    logic       idx2;
    logic       busy2;
    logic       terr2;
    logic [3:0] gnt4;
    logic [1:0] idx4;
    logic       busy4;
    logic       terr4;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] g2;
        logic       i2;
        logic       t2;
        logic [3:0] g4;
        logic [1:0] i4;
        string      tag;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    wb_arbiter_rr #(.NUMM(2), .TIMEOUT(8)) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_cyc       (m_cyc2),
        .bus_stb     (bus_stb),
        .bus_ack     (bus_ack),
        .bus_err     (bus_err),
        .gnt         (gnt2),
        .gnt_idx     (idx2),
        .busy        (busy2),
        .timeout_err (terr2)
    );

    wb_arbiter_rr #(.NUMM(4), .TIMEOUT(0)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_cyc       (m_cyc4),
        .bus_stb     (bus_stb),
        .bus_ack     (bus_ack),
        .bus_err     (bus_err),
        .gnt         (gnt4),
        .gnt_idx     (idx4),
        .busy        (busy4),
        .timeout_err (terr4)
    );

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s.%s actual=%0h expected=%0h", tag, fld, act, expv);
        end
    endtask

    // Monitor: one scoreboard entry describes the outputs after one clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.tag, "gnt2",  32'(gnt2),  32'(e.g2));
                chk(e.tag, "idx2",  32'(idx2),  32'(e.i2));
                chk(e.tag, "busy2", 32'(busy2), 32'(e.g2 != 2'b00));
                chk(e.tag, "terr2", 32'(terr2), 32'(e.t2));
                chk(e.tag, "gnt4",  32'(gnt4),  32'(e.g4));
                chk(e.tag, "idx4",  32'(idx4),  32'(e.i4));
                chk(e.tag, "busy4", 32'(busy4), 32'(e.g4 != 4'b0000));
                chk(e.tag, "terr4", 32'(terr4), 32'd0);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic r, input logic [1:0] m2, input logic s,
                       input logic a, input logic [3:0] m4,
                       input logic [1:0] eg2, input logic ei2, input logic et2,
                       input logic [3:0] eg4, input logic [1:0] ei4,
                       input string tag);
        exp_t e;
        @(negedge clk);
        rst_n   = r;
        m_cyc2  = m2;
        bus_stb = s;
        bus_ack = a;
        m_cyc4  = m4;
        e.g2  = eg2;
        e.i2  = ei2;
        e.t2  = et2;
        e.g4  = eg4;
        e.i4  = ei4;
        e.tag = tag;
        q.push_back(e);
    endtask

    initial begin
        // Reset and idle
        repeat (2) cyc(0, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0000, 2'd0, "reset");
        repeat (3) cyc(1, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0000, 2'd0, "idle");

        // Single master: one-cycle grant latency, hold, release
        repeat (4) cyc(1, 2'b01, 0, 0, 4'b0000, 2'b01, 0, 0, 4'b0000, 2'd0, "t1_hold");
        cyc(1, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0000, 2'd0, "t1_release");

        // Simultaneous requests after reset, back-to-back handover, alternation
        cyc(0, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0000, 2'd0, "t2_reset");
        repeat (2) cyc(1, 2'b11, 0, 0, 4'b0000, 2'b01, 0, 0, 4'b0000, 2'd0, "t2_first_m0");
        repeat (2) cyc(1, 2'b10, 0, 0, 4'b0000, 2'b10, 1, 0, 4'b0000, 2'd0, "t2_handover");
        cyc(1, 2'b00, 0, 0, 4'b0000, 2'b00, 1, 0, 4'b0000, 2'd0, "t2_idle_idx_hold");
        cyc(1, 2'b11, 0, 0, 4'b0000, 2'b01, 0, 0, 4'b0000, 2'd0, "t2_alternate");

        // No preemption while master 1 owns the bus
        cyc(1, 2'b10, 0, 0, 4'b0000, 2'b10, 1, 0, 4'b0000, 2'd0, "t3_m1_owns");
        repeat (20) cyc(1, 2'b11, 0, 0, 4'b0000, 2'b10, 1, 0, 4'b0000, 2'd0, "t3_no_preempt");
        cyc(1, 2'b01, 0, 0, 4'b0000, 2'b01, 0, 0, 4'b0000, 2'd0, "t3_m0_after");
        cyc(1, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0000, 2'd0, "rereq_idle");
        cyc(1, 2'b01, 0, 0, 4'b0000, 2'b01, 0, 0, 4'b0000, 2'd0, "rereq_alone");

        // Watchdog: pulse 8 cycles into a stall, one cycle wide; ACK at threshold wins
        cyc(1, 2'b01, 0, 0, 4'b0000, 2'b01, 0, 0, 4'b0000, 2'd0, "t4_setup");
        repeat (7) cyc(1, 2'b01, 1, 0, 4'b0000, 2'b01, 0, 0, 4'b0000, 2'd0, "t4_stall");
        cyc(1, 2'b01, 1, 0, 4'b0000, 2'b01, 0, 1, 4'b0000, 2'd0, "t4_timeout");
        cyc(1, 2'b01, 1, 0, 4'b0000, 2'b01, 0, 0, 4'b0000, 2'd0, "t4_pulse_width");
        cyc(1, 2'b01, 0, 0, 4'b0000, 2'b01, 0, 0, 4'b0000, 2'd0, "t4_clear");
        repeat (7) cyc(1, 2'b01, 1, 0, 4'b0000, 2'b01, 0, 0, 4'b0000, 2'd0, "t4_stall2");
        cyc(1, 2'b01, 1, 1, 4'b0000, 2'b01, 0, 0, 4'b0000, 2'd0, "t4_ack_wins");
        cyc(1, 2'b01, 0, 0, 4'b0000, 2'b01, 0, 0, 4'b0000, 2'd0, "t4_no_late");
        cyc(1, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0000, 2'd0, "t4_release");

        // Four masters: rotation 0,1,2,3,0 then skipping idle positions
        repeat (2) cyc(1, 2'b00, 0, 0, 4'b1111, 2'b00, 0, 0, 4'b0001, 2'd0, "t5_g0");
        cyc(1, 2'b00, 0, 0, 4'b1110, 2'b00, 0, 0, 4'b0010, 2'd1, "t5_g1");
        cyc(1, 2'b00, 0, 0, 4'b1111, 2'b00, 0, 0, 4'b0010, 2'd1, "t5_g1_hold");
        cyc(1, 2'b00, 0, 0, 4'b1101, 2'b00, 0, 0, 4'b0100, 2'd2, "t5_g2");
        cyc(1, 2'b00, 0, 0, 4'b1111, 2'b00, 0, 0, 4'b0100, 2'd2, "t5_g2_hold");
        cyc(1, 2'b00, 0, 0, 4'b1011, 2'b00, 0, 0, 4'b1000, 2'd3, "t5_g3");
        cyc(1, 2'b00, 0, 0, 4'b1111, 2'b00, 0, 0, 4'b1000, 2'd3, "t5_g3_hold");
        cyc(1, 2'b00, 0, 0, 4'b0111, 2'b00, 0, 0, 4'b0001, 2'd0, "t5_wrap_g0");
        cyc(1, 2'b00, 0, 0, 4'b1010, 2'b00, 0, 0, 4'b0010, 2'd1, "t5_skip_a");
        cyc(1, 2'b00, 0, 0, 4'b1001, 2'b00, 0, 0, 4'b1000, 2'd3, "t5_skip_b");
        cyc(1, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0000, 2'd3, "t5_idle");

        // Reset during a granted, stalled transfer
        cyc(1, 2'b10, 1, 0, 4'b0100, 2'b10, 1, 0, 4'b0100, 2'd2, "t6_granted");
        cyc(1, 2'b10, 1, 0, 4'b0100, 2'b10, 1, 0, 4'b0100, 2'd2, "t6_hold");
        cyc(0, 2'b10, 1, 0, 4'b0100, 2'b00, 0, 0, 4'b0000, 2'd0, "t6_reset");
        cyc(1, 2'b11, 0, 0, 4'b1111, 2'b01, 0, 0, 4'b0001, 2'd0, "t6_after_reset");
        cyc(1, 2'b00, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b0000, 2'd0, "end");

        // Let the monitor drain the scoreboard, bounded
        for (int n = 0; n < 10 && q.size() > 0; n++) begin
            @(posedge clk);
            #2;
        end
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_rr.md
Name: wb_arbiter_rr

Overview:
Round-robin bus arbiter for the Wishbone shared-bus interconnect. It decides which of NUMM masters (e.g. Ibex instruction port = 0, data port = 1) owns the shared bus, and holds ownership for the whole CYC assertion. The interconnect uses gnt_idx to steer its address/data/ack muxes. A stall watchdog terminates transfers that the addressed slave never acknowledges.

Parameters:
NUMM, 2, number of masters (2..16)
TIMEOUT, 256, stall cycles (STB high, no ACK/ERR) before a forced error; 0 disables the watchdog

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
m_cyc  input  NUMM  CYC of each master, bit i = master i
bus_stb  input  1  STB of the currently granted master (muxed by interconnect)
bus_ack  input  1  ACK returned by the selected slave
bus_err  input  1  ERR returned by the selected slave
gnt  output  NUMM  one-hot grant, registered
gnt_idx  output  $clog2(NUMM) (min 1)  binary index of granted master; valid when busy
busy  output  1  bus owned (gnt != 0)
timeout_err  output  1  one-cycle pulse; interconnect ORs it into granted master's ERR

Behaviour:
- Reset (rst_n=0 at clk edge): gnt=0, gnt_idx=0, busy=0, timeout_err=0, watchdog count=0, last=NUMM-1 (master 0 wins first). Applies mid-transfer; grant is dropped immediately on the next edge, no handshake completion.
- States: IDLE (busy=0), GRANT (busy=1).
- Round-robin pick: first i with m_cyc[i]=1, scanning last+1, last+2, ... modulo NUMM.
- IDLE: any m_cyc set -> GRANT with the pick; gnt/gnt_idx/busy update on that edge. Latency m_cyc rise -> gnt = 1 cycle. Nothing set -> stay IDLE.
- GRANT: while m_cyc[gnt_idx]=1, hold grant; other requests ignored regardless of position (no preemption).
- GRANT, m_cyc[gnt_idx]=0: last := gnt_idx. If another master requests, grant the pick (scanning from gnt_idx+1) on the same edge: back-to-back handover, no idle cycle. Else -> IDLE, gnt=0.
- Owner releases and re-requests the same cycle it is sampled low: re-request is lower priority than any other pending master; wins only if no other requests.
- gnt is always one-hot or zero; gnt_idx holds its value in IDLE.
- Watchdog (TIMEOUT>0): count increments each GRANT cycle with bus_stb=1, bus_ack=0, bus_err=0. It clears on bus_ack, bus_err, bus_stb=0, state IDLE, or grant change. When count = TIMEOUT-1 and stall persists, timeout_err=1 for the next cycle and count clears. Count width $clog2(TIMEOUT+1); no wrap beyond TIMEOUT-1.
- timeout_err does not release the grant; the master sees ERR and drops CYC normally.
- bus_ack and timeout threshold in the same cycle: ACK wins, no timeout_err.
- TIMEOUT=0: timeout_err tied 0, counter removed.

Test Plan:
- Reset then m_cyc=2'b01 at cycle 5 -> gnt=2'b01, gnt_idx=0, busy=1 at cycle 6; hold while m_cyc[0]=1; after m_cyc=0, gnt=0 and busy=0 next cycle.
- m_cyc=2'b11 simultaneously after reset -> master 0 granted first. Master 0 drops CYC -> gnt=2'b10 on the next edge, no idle cycle. Master 1 drops, then both request again -> master 0 granted (alternation).
- Master 1 owns the bus while master 0 requests continuously for 20 cycles -> gnt stays 2'b10 until m_cyc[1]=0, then 2'b01.
- TIMEOUT=8, granted master holds bus_stb=1 with no ack -> timeout_err=1 exactly 8 cycles after the stall begins, one cycle wide, grant unchanged. ACK on the 8th stall cycle -> no pulse.
- NUMM=4, m_cyc=4'b1111, each owner drops CYC after 2 cycles -> grant order 0,1,2,3,0; gnt_idx matches.
- rst_n=0 for one cycle during a granted transfer -> next cycle gnt=0, busy=0, timeout_err=0; the following grant goes to master 0 if it requests.
